// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter for a single-port data memory with read return routing
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int RD_LAT   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_STALL,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    input  logic              DMA_REQ,
    input  logic [ADDR_W-1:0] DMA_ADDR,
    output logic              DMA_GNT,
    output logic              DMA_RVALID,
    output logic [DATA_W-1:0] DMA_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WD,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RD
);

    localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WAIT);

    // Count of consecutive cycles the DMA lost to the CPU; never exceeds MAX_CNT.
    logic [CNT_W-1:0]  r_wait_cnt;
    // Tag pipeline: index 0 is the newest issue, RD_LAT-1 lines up with MEM_RD.
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_dma;

    logic              w_force;
    logic              w_cpu_gnt;
    logic              w_dma_gnt;
    logic              w_rd_issue;
    logic              w_tail_vld;
    logic [CNT_W-1:0]  w_wait_nxt;

    // DMA has starved long enough: it takes this cycle even though the CPU is asking.
    assign w_force    = CPU_REQ & DMA_REQ & (r_wait_cnt == MAX_CNT);
    assign w_cpu_gnt  = CPU_REQ & ~w_force;
    assign w_dma_gnt  = DMA_REQ & (~CPU_REQ | w_force);
    assign w_rd_issue = w_dma_gnt | (w_cpu_gnt & ~CPU_WE);

    // Starvation counter advances only on a cycle where the DMA was actually blocked.
    always_comb begin
        w_wait_nxt = '0;
        if (CPU_REQ && DMA_REQ && !w_force) begin
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Read tag shift register; writes and idle cycles push an invalid tag so issue order is kept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tag_vld <= '0;
            r_tag_dma <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_issue;
            r_tag_dma[0] <= w_dma_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_dma[i] <= r_tag_dma[i-1];
            end
        end
    end

    // Returns are squelched while reset is held so in-flight reads are dropped cleanly.
    assign w_tail_vld = r_tag_vld[RD_LAT-1] & ~RST;

    assign CPU_STALL  = CPU_REQ & ~w_cpu_gnt;
    assign DMA_GNT    = w_dma_gnt;
    assign MEM_ADDR   = w_cpu_gnt ? CPU_ADDR : (w_dma_gnt ? DMA_ADDR : '0);
    assign MEM_WD     = w_cpu_gnt ? CPU_WDATA : '0;
    assign MEM_WE     = w_cpu_gnt & CPU_WE & ~RST;

    assign CPU_RVALID = w_tail_vld & ~r_tag_dma[RD_LAT-1];
    assign DMA_RVALID = w_tail_vld &  r_tag_dma[RD_LAT-1];
    assign CPU_RDATA  = CPU_RVALID ? MEM_RD : '0;
    assign DMA_RDATA  = DMA_RVALID ? MEM_RD : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at RD_LAT 1 and 2
module tb_mem_port_arbiter;

    localparam int MAXW = 3;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0;

    logic        cpu_stall1, cpu_rvalid1, dma_gnt1, dma_rvalid1, mem_we1;
    logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wd1, mem_rd1;
    logic        cpu_stall2, cpu_rvalid2, dma_gnt2, dma_rvalid2, mem_we2;
    logic [31:0] cpu_rdata2, dma_rdata2, mem_addr2, mem_wd2, mem_rd2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW), .RD_LAT(1)) u_dut1 (
        .CLK(CLK), .RST(rst),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_STALL(cpu_stall1), .CPU_RVALID(cpu_rvalid1), .CPU_RDATA(cpu_rdata1),
        .DMA_REQ(dma_req), .DMA_ADDR(dma_addr), .DMA_GNT(dma_gnt1),
        .DMA_RVALID(dma_rvalid1), .DMA_RDATA(dma_rdata1),
        .MEM_ADDR(mem_addr1), .MEM_WD(mem_wd1), .MEM_WE(mem_we1), .MEM_RD(mem_rd1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW), .RD_LAT(2)) u_dut2 (
        .CLK(CLK), .RST(rst),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_STALL(cpu_stall2), .CPU_RVALID(cpu_rvalid2), .CPU_RDATA(cpu_rdata2),
        .DMA_REQ(dma_req), .DMA_ADDR(dma_addr), .DMA_GNT(dma_gnt2),
        .DMA_RVALID(dma_rvalid2), .DMA_RDATA(dma_rdata2),
        .MEM_ADDR(mem_addr2), .MEM_WD(mem_wd2), .MEM_WE(mem_we2), .MEM_RD(mem_rd2)
    );

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    logic [31:0] a1_q = '0, a2_q0 = '0, a2_q1 = '0;
    always @(posedge CLK) begin
        a1_q  <= mem_addr1;
        a2_q0 <= mem_addr2;
        a2_q1 <= a2_q0;
    end
    assign mem_rd1 = mdata(a1_q);
    assign mem_rd2 = mdata(a2_q1);

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk32(nm, 32'(act), 32'(exp));
    endtask

    // Model: grant by priority/starvation rule, reads recorded per issue cycle.
    int          cyc = 0;
    int          m_wait = 0;
    bit          iss_v [0:1023];
    bit          iss_d [0:1023];
    logic [31:0] iss_a [0:1023];
    logic        e_cg, e_dg;
    logic [31:0] e_addr;

    task automatic cmp_arb(input string n, input logic st, input logic g,
                           input logic [31:0] a, input logic [31:0] wd, input logic we);
        chk1 ($sformatf("%s stall c%0d", n, cyc), st, cpu_req && !e_cg);
        chk1 ($sformatf("%s dma_gnt c%0d", n, cyc), g, e_dg);
        chk32($sformatf("%s mem_addr c%0d", n, cyc), a, e_addr);
        chk32($sformatf("%s mem_wd c%0d", n, cyc), wd, e_cg ? cpu_wdata : 32'h0);
        chk1 ($sformatf("%s mem_we c%0d", n, cyc), we, e_cg && cpu_we && !rst);
    endtask

    task automatic cmp_ret(input string n, input int lat, input logic cv, input logic [31:0] cd,
                           input logic dv, input logic [31:0] dd);
        int          idx;
        logic        ev, evc, evd;
        logic [31:0] ed;
        idx = (cyc >= lat) ? cyc - lat : 0;
        ev  = !rst && (cyc >= lat) && iss_v[idx];
        evc = ev && !iss_d[idx];
        evd = ev && iss_d[idx];
        ed  = mdata(iss_a[idx]);
        chk1 ($sformatf("%s cpu_rvalid c%0d", n, cyc), cv, evc);
        chk32($sformatf("%s cpu_rdata c%0d", n, cyc), cd, evc ? ed : 32'h0);
        chk1 ($sformatf("%s dma_rvalid c%0d", n, cyc), dv, evd);
        chk32($sformatf("%s dma_rdata c%0d", n, cyc), dd, evd ? ed : 32'h0);
    endtask

    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            e_dg   = dma_req && (!cpu_req || m_wait == MAXW);
            e_cg   = cpu_req && !e_dg;
            e_addr = e_cg ? cpu_addr : (e_dg ? dma_addr : 32'h0);
            cmp_arb("d1", cpu_stall1, dma_gnt1, mem_addr1, mem_wd1, mem_we1);
            cmp_arb("d2", cpu_stall2, dma_gnt2, mem_addr2, mem_wd2, mem_we2);
            cmp_ret("d1", 1, cpu_rvalid1, cpu_rdata1, dma_rvalid1, dma_rdata1);
            cmp_ret("d2", 2, cpu_rvalid2, cpu_rdata2, dma_rvalid2, dma_rdata2);
            if (rst) begin
                m_wait = 0;
                for (int i = (cyc > 4 ? cyc - 4 : 0); i <= cyc; i++) iss_v[i] = 1'b0;
            end else begin
                iss_v[cyc] = e_dg || (e_cg && !cpu_we);
                iss_d[cyc] = e_dg;
                iss_a[cyc] = e_addr;
                m_wait     = (cpu_req && dma_req && !e_dg) ? m_wait + 1 : 0;
            end
            cyc++;
        end
    end

    task automatic drive(input logic r, input logic cq, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dq, input logic [31:0] da);
        @(posedge CLK);
        #1;
        rst = r; cpu_req = cq; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dq; dma_addr = da;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk1("rst dma_gnt", dma_gnt1, 1'b0);
        chk1("rst stall", cpu_stall1, 1'b0);
        chk1("rst mem_we", mem_we1, 1'b0);
        chk1("rst rvalid", cpu_rvalid1 | dma_rvalid1 | cpu_rvalid2 | dma_rvalid2, 1'b0);

        drive(0, 1, 0, 32'h10, 0, 0, 0);
        chk32("rd addr", mem_addr1, 32'h10);
        chk1("rd we", mem_we1, 1'b0);
        chk1("rd stall", cpu_stall1, 1'b0);
        idle(1);
        chk1("rd lat1 rvalid", cpu_rvalid1, 1'b1);
        chk32("rd lat1 rdata", cpu_rdata1, 32'hA5A5_0010);
        chk1("rd lat1 dma_rvalid", dma_rvalid1, 1'b0);
        chk1("rd lat2 early", cpu_rvalid2, 1'b0);
        idle(1);
        chk1("rd lat2 rvalid", cpu_rvalid2, 1'b1);
        chk32("rd lat2 rdata", cpu_rdata2, 32'hA5A5_0010);
        chk1("rd lat1 once", cpu_rvalid1, 1'b0);

        drive(0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0, 0);
        chk1("wr we", mem_we1, 1'b1);
        chk32("wr wd", mem_wd1, 32'hDEAD_BEEF);
        chk32("wr addr", mem_addr2, 32'h20);
        idle(3);

        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 32'h200 + k, 0, 1, 32'h300 + k);
            chk1($sformatf("contend gnt k%0d", k), dma_gnt1, (k % 4) == 3);
            chk1($sformatf("contend stall k%0d", k), cpu_stall2, (k % 4) == 3);
            chk32($sformatf("contend addr k%0d", k), mem_addr1,
                  ((k % 4) == 3) ? 32'h300 + k : 32'h200 + k);
        end
        idle(3);

        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 1, 32'h100 + k);
            chk1($sformatf("dma only gnt k%0d", k), dma_gnt1, 1'b1);
            chk1($sformatf("dma only stall k%0d", k), cpu_stall1, 1'b0);
        end
        idle(1);
        chk1("dma last rvalid", dma_rvalid1, 1'b1);
        chk32("dma last rdata", dma_rdata1, 32'hA5A5_0103);
        idle(2);

        drive(0, 1, 0, 32'h30, 0, 1, 32'h31);
        drive(0, 1, 0, 32'h40, 0, 1, 32'h41);
        drive(1, 1, 1, 32'h44, 32'h1234_5678, 1, 32'h64);
        chk1("rst cyc mem_we", mem_we1, 1'b0);
        chk32("rst cyc mem_wd", mem_wd1, 32'h1234_5678);
        chk1("rst cyc cpu wins", dma_gnt1, 1'b0);
        chk1("rst cyc rvalid1", cpu_rvalid1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 32'h50 + k, 0, 1, 32'h60 + k);
            if (k == 0) begin
                chk1("post rst dropped rd", cpu_rvalid2, 1'b0);
                chk32("post rst addr", mem_addr2, 32'h50);
            end
            chk1($sformatf("post rst gnt k%0d", k), dma_gnt2, k == 3);
        end

        drive(0, 1, 0, 32'h70, 0, 1, 32'h80);
        drive(0, 1, 0, 32'h71, 0, 1, 32'h81);
        drive(0, 1, 1, 32'h72, 32'h5555_AAAA, 0, 0);
        chk1("dma drop stall", cpu_stall1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 32'h90 + k, 0, 1, 32'hA0 + k);
            chk1($sformatf("recontend gnt k%0d", k), dma_gnt1, k == 3);
        end
        idle(3);

        @(negedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline memory stage (CPU requester) and the image-readout DMA requester that streams pixels to the display path.
- CPU has fixed priority. A starvation counter forces a DMA grant after MAX_WAIT blocked cycles, stalling the pipeline for that cycle.
- Tracks in-flight reads through the memory read latency and routes returning data to the requester that issued the read.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 8, consecutive cycles DMA may be blocked before it is forced (>=1).
- RD_LAT, 1, memory read latency in cycles (>=1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- CPU_REQ  in  1  pipeline access request.
- CPU_WE  in  1  1 = write, 0 = read; valid with CPU_REQ.
- CPU_ADDR  in  ADDR_W  CPU address.
- CPU_WDATA  in  DATA_W  CPU write data.
- CPU_STALL  out  1  CPU request not served this cycle; pipeline must hold.
- CPU_RVALID  out  1  CPU read data valid.
- CPU_RDATA  out  DATA_W  CPU read data.
- DMA_REQ  in  1  DMA read request; DMA never writes.
- DMA_ADDR  in  ADDR_W  DMA address.
- DMA_GNT  out  1  DMA request accepted this cycle.
- DMA_RVALID  out  1  DMA read data valid.
- DMA_RDATA  out  DATA_W  DMA read data.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WD  out  DATA_W  memory write data.
- MEM_WE  out  1  memory write enable.
- MEM_RD  in  DATA_W  memory read data, RD_LAT cycles after address.

Behaviour:
- Grant decision is combinational from CPU_REQ, DMA_REQ and the registered wait_cnt. Winner drives MEM_* in the same cycle.
- Arbitration, per cycle:
  - Neither requests: no grant; MEM_ADDR=0, MEM_WD=0, MEM_WE=0; wait_cnt<=0.
  - CPU only: CPU granted; CPU_STALL=0; wait_cnt<=0.
  - DMA only: DMA_GNT=1; wait_cnt<=0.
  - Both, wait_cnt<MAX_WAIT: CPU granted; DMA_GNT=0; wait_cnt<=wait_cnt+1.
  - Both, wait_cnt==MAX_WAIT: DMA_GNT=1; CPU_STALL=1; wait_cnt<=0.
- CPU_STALL=1 only when CPU_REQ=1 and the CPU is not granted. CPU_STALL=0 whenever CPU_REQ=0.
- MEM_WE=1 only when the CPU is granted and CPU_WE=1. MEM_WD=CPU_WDATA when the CPU is granted, otherwise 0.
- Read return tracking:
  - RD_LAT-deep shift register of tags {valid, owner}.
  - A tag enters when a read is granted (CPU read or DMA). CPU writes insert an invalid tag.
  - At the tail: owner CPU gives CPU_RVALID=1; owner DMA gives DMA_RVALID=1.
  - CPU_RDATA and DMA_RDATA are driven from MEM_RD when their RVALID is 1, otherwise 0.
  - Exactly one RVALID per granted read, in issue order.
  - RVALID never asserts for a write or an ungranted request.
- Reset, including mid-operation:
  - wait_cnt=0 and all tags invalid.
  - In-flight reads are dropped: no RVALID in the cycle after reset nor for reads issued before it.
  - During RST=1, arbitration outputs follow the same combinational rules, but the memory write is suppressed (MEM_WE=0).
- After reset, outputs idle: CPU_STALL=0 when CPU_REQ=0, DMA_GNT=0, both RVALID=0, MEM_WE=0.
- Requesters may change ADDR/WE every cycle. An ungranted request must be held by its requester; no request is buffered inside the block.
- Back-to-back grants are permitted every cycle. Read and write interleave freely.

Test Plan:
- Reset, then CPU read at 0x10 with MEM_RD model returning 0xA5A5_0010 (RD_LAT=1) -> same cycle MEM_ADDR=0x10, MEM_WE=0, CPU_STALL=0; next cycle CPU_RVALID=1, CPU_RDATA=0xA5A5_0010, DMA_RVALID=0.
- CPU write 0x20 with data 0xDEAD_BEEF -> MEM_WE=1, MEM_WD=0xDEAD_BEEF; no RVALID in any following cycle.
- MAX_WAIT=3, CPU_REQ and DMA_REQ held high -> CPU granted on cycles 0–2. Cycle 3: DMA_GNT=1, CPU_STALL=1, MEM_ADDR=DMA_ADDR. Pattern then repeats with period 4; DMA_RVALID lags each DMA_GNT by RD_LAT.
- DMA only, addresses 0x100..0x103 on consecutive cycles -> DMA_GNT=1 every cycle; four DMA_RVALID pulses in order; CPU_STALL=0 throughout.
- RD_LAT=2, CPU read issued, RST=1 on the next cycle -> no CPU_RVALID ever for that read; wait_cnt=0; first post-reset arbitration gives CPU priority.
- Both request with wait_cnt=2, then DMA_REQ drops -> wait_cnt returns to 0; a later contention needs MAX_WAIT more blocked cycles before DMA is forced.
